// File: rtl/regfile_pkg.sv
// regfile_pkg: state encoding and constant helpers shared by the register file.
package regfile_pkg;

    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    // Replicate as {W{zero_bit()}} to build a zero word of any width.
    function automatic logic zero_bit();
        return 1'b0;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: asynchronous read mux with zero forcing and optional
// write-first forwarding (REGFILE_BYPASS_EN).
module regfile_read_port #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int ZERO_REG = 1
) (
    input  logic [XLEN-1:0] mem [NREGS],
    input  logic            run,
    input  logic [AW-1:0]   raddr,
    input  logic            wr_ok,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);
    import regfile_pkg::*;

    logic hit;

`ifdef REGFILE_BYPASS_EN
    assign hit = wr_ok && raddr == waddr;
`else
    logic unused_fwd;
    assign hit = 1'b0;
    assign unused_fwd = ^{wr_ok, waddr, wdata};
`endif

    always_comb begin
        rdata = (!run || (ZERO_REG != 0 && raddr == '0)) ? {XLEN{zero_bit()}} :
                hit ? wdata : mem[raddr];
    end

endmodule

// File: rtl/regfile_2r1w_clr.sv
// regfile_2r1w_clr: 2-read/1-write register file with a clear sweep after reset
// or on clear_req; REGFILE_BYPASS_EN enables write-to-read forwarding.
module regfile_2r1w_clr #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear_req,
    output logic            ready,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr_a,
    output logic [XLEN-1:0] rdata_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_b,
    output logic            wr_drop
);
    import regfile_pkg::*;

    logic [XLEN-1:0] mem [NREGS];
    state_t          state, state_n;
    logic [AW-1:0]   idx, idx_n;
    logic            clearing, wr_ok, drop_n;

    // NREGS is a power of two, so idx wraps to 0 on its own after the last entry.
    always_comb begin
        clearing = state == ST_CLEAR;
        state_n = clearing ? (&idx ? ST_RUN : ST_CLEAR) : (clear_req ? ST_CLEAR : ST_RUN);
        idx_n = clearing ? idx + 1'b1 : '0;
        wr_ok = we && !clearing && !clear_req && !(ZERO_REG != 0 && waddr == '0);
        drop_n = we && (clearing || clear_req);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_CLEAR;
            idx <= '0;
            wr_drop <= 1'b0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            wr_drop <= drop_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clearing)
                mem[idx] <= {XLEN{zero_bit()}};
            else if (wr_ok)
                mem[waddr] <= wdata;
        end
    end

    assign ready = !clearing;

    regfile_read_port #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .ZERO_REG(ZERO_REG)) u_rd_a (
        .mem(mem), .run(!clearing), .raddr(raddr_a), .wr_ok(wr_ok),
        .waddr(waddr), .wdata(wdata), .rdata(rdata_a)
    );

    regfile_read_port #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .ZERO_REG(ZERO_REG)) u_rd_b (
        .mem(mem), .run(!clearing), .raddr(raddr_b), .wr_ok(wr_ok),
        .waddr(waddr), .wdata(wdata), .rdata(rdata_b)
    );

endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// tb_regfile_2r1w_clr: directed table, corner sequences and random traffic
// against a whole-file reference model.
module tb_regfile_2r1w_clr;

    logic        clk = 1'b0;
    logic        reset, clear_req, we;
    logic [4:0]  waddr, raddr_a, raddr_b;
    logic [31:0] wdata;
    logic        ready, wr_drop, ready_z, wr_drop_z;
    logic [31:0] rdata_a, rdata_b, rdata_a_z, rdata_b_z;
    int          total = 0, bad = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    regfile_2r1w_clr dut (
        .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready),
        .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b),
        .wr_drop(wr_drop)
    );

    regfile_2r1w_clr #(.ZERO_REG(0)) dut_z (
        .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready_z),
        .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rdata_a_z), .raddr_b(raddr_b), .rdata_b(rdata_b_z),
        .wr_drop(wr_drop_z)
    );

    // Model: a clear zeroes the whole file at once and just counts down the
    // edges until it becomes usable again; reads are masked meanwhile.
    logic [31:0] m [32];
    int          busy;
    logic        m_drop;

    function automatic logic [31:0] exp_rd(logic [4:0] ra);
        if (busy != 0 || ra == 0) return 32'h0;
        if (BYP && we && !clear_req && ra == waddr) return wdata;
        return m[ra];
    endfunction

    task automatic model_edge();
        if (reset) begin
            busy = 32;
            m_drop = 1'b0;
            foreach (m[i]) m[i] = 32'h0;
        end else if (busy > 0) begin
            m_drop = we;
            busy--;
        end else if (clear_req) begin
            m_drop = we;
            busy = 32;
            foreach (m[i]) m[i] = 32'h0;
        end else begin
            m_drop = 1'b0;
            if (we && waddr != 0) m[waddr] = wdata;
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic edge_only();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        chk("ready", ready, busy == 0);
        chk("ready_z", ready_z, busy == 0);
        chk("rdata_a", rdata_a, exp_rd(raddr_a));
        chk("rdata_b", rdata_b, exp_rd(raddr_b));
        chk("wr_drop", wr_drop, m_drop);
        edge_only();
    endtask

    task automatic idle();
        we = 1'b0;
        clear_req = 1'b0;
        reset = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra, rb;
        logic [31:0] ea, eb;
    } vec_t;

    vec_t vt [9];

    initial begin
        int lo, drops, n;
        vt[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  BYP ? 32'hDEADBEEF : 32'h0, 32'h0};
        vt[1] = '{1'b1, 5'd31, 32'h12345678, 5'd5,  5'd31, 32'hDEADBEEF, BYP ? 32'h12345678 : 32'h0};
        vt[2] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'hDEADBEEF, 32'h12345678};
        vt[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0};
        vt[4] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0, 32'h0};
        vt[5] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0};
        vt[6] = '{1'b1, 5'd9,  32'h1,        5'd9,  5'd9,  BYP ? 32'h1 : 32'h0, BYP ? 32'h1 : 32'h0};
        vt[7] = '{1'b1, 5'd9,  32'h2,        5'd9,  5'd9,  BYP ? 32'h2 : 32'h1, BYP ? 32'h2 : 32'h1};
        vt[8] = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd9,  32'h2, 32'h2};

        reset = 1'b1; clear_req = 1'b0; we = 1'b0;
        waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
        edge_only();
        edge_only();
        reset = 1'b0;

        // Reset sweep: ready low for exactly 32 edges, then every entry reads 0.
        lo = 0;
        for (int i = 0; i < 32; i++) begin
            lo += int'(!ready);
            tick();
        end
        chk("sweep_lo", lo, 32);
        chk("sweep_ready", ready, 1);
        for (int i = 0; i < 32; i++) begin
            raddr_a = 5'(i);
            raddr_b = 5'(31 - i);
            tick();
        end

        // Directed table: basic write/read, r0 handling, same-cycle r9.
        foreach (vt[i]) begin
            we = vt[i].we; waddr = vt[i].wa; wdata = vt[i].wd;
            raddr_a = vt[i].ra; raddr_b = vt[i].rb;
            @(negedge clk);
            chk($sformatf("vec%0d_a", i), rdata_a, vt[i].ea);
            chk($sformatf("vec%0d_b", i), rdata_b, vt[i].eb);
            chk($sformatf("vec%0d_drop", i), wr_drop, 0);
            edge_only();
        end
        we = 1'b0;
        raddr_a = 5'd0; raddr_b = 5'd0;
        @(negedge clk);
        chk("z0_r0_a", rdata_a_z, 32'hFFFFFFFF);
        chk("z0_r0_b", rdata_b_z, 32'hFFFFFFFF);

        // Clear request with a colliding write, and a write during the sweep.
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
        tick();
        clear_req = 1'b1; waddr = 5'd8; wdata = 32'h5A5A5A5A;
        tick();
        idle();
        chk("clr_drop", wr_drop, 1);
        lo = 0;
        drops = 0;
        for (int i = 0; i < 32; i++) begin
            lo += int'(!ready);
            if (i > 0) drops += int'(wr_drop);
            we = (i == 5);
            waddr = 5'd3;
            wdata = 32'h33333333;
            tick();
        end
        we = 1'b0;
        chk("clr_lo", lo, 32);
        chk("clr_sweep_drops", drops, 1);
        chk("clr_ready", ready, 1);
        raddr_a = 5'd7; raddr_b = 5'd8;
        @(negedge clk);
        chk("clr_r7", rdata_a, 32'h0);
        chk("clr_r8", rdata_b, 32'h0);
        raddr_a = 5'd3;
        @(negedge clk);
        chk("clr_r3", rdata_a, 32'h0);
        edge_only();

        // Reset at sweep index 17 restarts the full sweep.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        chk("midrst_len", n, 32);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            we = $urandom_range(1) == 1;
            waddr = 5'($urandom);
            wdata = $urandom;
            raddr_a = ($urandom_range(2) == 0) ? waddr : 5'($urandom);
            raddr_b = ($urandom_range(2) == 0) ? waddr : 5'($urandom);
            clear_req = $urandom_range(59) == 0;
            reset = $urandom_range(299) == 0;
            tick();
        end
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
